imem_loader: RTL
================

# imem_loader

Boot-time writer for the CPU's instruction memory. Accepts a byte stream (length header followed by little-endian 32-bit instruction words) over a valid/ready handshake, assembles words, and issues one-cycle word writes to the instruction memory's write port. Holds the CPU in stall (`cpu_hold`) until a complete image has been written, then releases it.

## Interface
- `DEPTH`, 64: instruction memory depth in words; maximum accepted image length.
- `ADDR_W`, 6: word-address width; log2(`DEPTH`).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `byte_valid`  in  1: source has a byte on `byte_data`.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `wr_en`  out  1: instruction memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W: word index (memory byte address = `wr_addr`<<2).
- `wr_data`  out  32: assembled instruction word.
- `cpu_hold`  out  1: CPU stall/reset hold.
- `done`  out  1: one-cycle pulse when the last word has been written.
- `err`  out  1: sticky bad-length flag.

## Operation
- Byte accepted when `byte_valid & byte_ready` at a rising edge; no other byte is consumed.
- Stream format: `len[7:0]`, `len[15:8]` (N, word count), then 4·N bytes; word k's bytes go to `wr_data[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` in arrival order.
- States:
  - IDLE: `byte_ready`=0. `start` → LEN0.
  - LEN0: `byte_ready`=1. Accepted byte → N[7:0], then LEN1.
  - LEN1: `byte_ready`=1. Accepted byte → N[15:8], then a check: if N==0 or N>DEPTH → ERR; otherwise word index=0, byte count=0, and → DATA.
  - DATA: `byte_ready`=1. Each accepted byte goes to the lane selected by the 2-bit byte count, and the byte count increments. On acceptance of lane 3 → WRITE.
  - WRITE: `byte_ready`=0. `wr_en`=1 for exactly this cycle, with `wr_addr`=word index and `wr_data`=assembled word. Then: if index==N-1 → DONE; otherwise index+1 → DATA.
  - DONE: `done`=1 during the first cycle only. `cpu_hold`=0. `byte_ready`=0. `start` → LEN0.
  - ERR: `err`=1, `cpu_hold`=1, `byte_ready`=0. `start` → LEN0 and clears `err`.
- `cpu_hold` is 1 in every state except DONE and IDLE-after-DONE. Implementation: a `loaded` flag, set on entering DONE and cleared by an accepted `start`.
- `start` in LEN0/LEN1/DATA/WRITE is ignored; the current load continues.
- Extra bytes after the last word are not accepted (`byte_ready`=0).
- `wr_addr` never exceeds DEPTH-1. The length check guarantees this; the index does not wrap.
- N is compared at 16 bits against DEPTH; there is no truncation before the check.

## Timing
- Reset values: state=IDLE, `byte_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `err`=0, `loaded`=0.
- Reset mid-load aborts immediately. Words already written stay in memory; `cpu_hold` returns to 1.
- `byte_ready` is a registered state decode and does not depend on `byte_valid` combinationally.
- Latency: `wr_en` is asserted on the cycle after the 4th byte of a word is accepted.
- Minimum load: 3 + 5·N cycles from `start` with `byte_valid` held high (1 start→LEN0 cycle, 2 header, 4 bytes + 1 WRITE per word).
- `done` is asserted the cycle after the final WRITE cycle. `cpu_hold` falls in that same cycle.
- Stalls (`byte_valid`=0) may occur in any accepting state, for any length, without effect on assembled data.
- `wr_data`/`wr_addr` hold their last values outside WRITE. The memory must sample only when `wr_en`=1.

## Test plan
- Normal load: `start`; stream 02 00, 13 01 01 FE, 23 2E 81 00 → writes (0, 0xFE010113) then (1, 0x00812E23); `done` pulses once; `cpu_hold` falls with `done`; total 13 cycles.
- Backpressure gaps: same image with `byte_valid` toggling 1/0 every cycle → identical writes; `byte_ready` never low in DATA; no duplicated or lost bytes.
- Bad lengths: header 00 00 → ERR, `err`=1, `cpu_hold`=1, no `wr_en`. Header 41 00 (65) → same. Subsequent `start` clears `err` and a valid load succeeds.
- Full depth: N=64 (40 00) with word k = k·0x01010101 → 64 writes; last is `wr_addr`=63; `done` follows; byte 257 of the data is not accepted.
- Reset mid-load: assert `rst_n`=0 after word 0 written → all outputs at reset values asynchronously. A new load from `start` rewrites from `wr_addr`=0.
- Ignored start: pulse `start` while in DATA → no restart; the load completes normally with the correct N writes.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed little-endian byte stream into instruction
// memory word writes, holding the CPU until a complete image has landed.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
    state_t            r_state, w_next;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_cnt;
    logic [23:0]       r_asm;
    logic              r_loaded, r_done;
    logic              w_take, w_start, w_len_bad, w_last;
    logic [15:0]       w_n;
    assign byte_ready = r_state inside {S_LEN0, S_LEN1, S_DATA};
    assign wr_en      = r_state == S_WRITE;
    assign err        = r_state == S_ERR;
    assign done       = r_done;
    assign cpu_hold   = ~r_loaded;
    assign w_take     = byte_valid & byte_ready;
    assign w_start    = start & (r_state inside {S_IDLE, S_DONE, S_ERR});
    assign w_n        = {byte_data, r_len[7:0]};
    // full 16-bit compare so a large N cannot alias onto a small legal one
    assign w_len_bad  = (w_n == 16'd0) || (w_n > 16'(DEPTH));
    assign w_last     = 16'(r_idx) == r_len - 16'd1;
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = start ? S_LEN0 : r_state;
            S_LEN0:  w_next = w_take ? S_LEN1 : S_LEN0;
            S_LEN1:  w_next = w_take ? (w_len_bad ? S_ERR : S_DATA) : S_LEN1;
            S_DATA:  w_next = (w_take && r_cnt == 2'd3) ? S_WRITE : S_DATA;
            S_WRITE: w_next = w_last ? S_DONE : S_DATA;
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_asm    <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= r_state == S_WRITE && w_last;
            if (w_start)
                r_loaded <= 1'b0;
            else if (r_state == S_WRITE && w_last)
                r_loaded <= 1'b1;
            if (r_state == S_LEN0 && w_take)
                r_len[7:0] <= byte_data;
            if (r_state == S_LEN1 && w_take) begin
                r_len[15:8] <= byte_data;
                r_idx       <= '0;
                r_cnt       <= '0;
            end
            // output word is latched whole on lane 3 so wr_data holds outside WRITE
            if (r_state == S_DATA && w_take) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    wr_addr <= r_idx;
                    wr_data <= {byte_data, r_asm};
                end else
                    r_asm[8*r_cnt +: 8] <= byte_data;
            end
            if (r_state == S_WRITE && !w_last)
                r_idx <= r_idx + 1'b1;
        end
    end
endmodule
